ysyx_ifu_redirect: RTL

YSYX_IFU_REDIRECT -- requirements
Module: ysyx_ifu_redirect

---
 rtl/ysyx_ifu_redirect_pkg.sv | 49 ++++
 rtl/ysyx_ifu_redirect.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_ifu_redirect_pkg.sv
// ---------------------------------------------------------------------------
// ysyx_ifu_redirect_pkg
//   Shared definitions for the IFU redirect controller:
//     - YSYX_XLEN default (32) when the build does not provide one
//     - YSYX_FENCE_TIMEOUT : default fence.i acknowledge wait budget
//     - redir_state_e      : controller FSM states
//     - post_flush_state / post_fence_t_state : sequencing helpers
//   Related configuration macro: YSYX_BTB_UPDATE_EN (used by ysyx_ifu_redirect).
// ---------------------------------------------------------------------------
`ifndef YSYX_XLEN
`define YSYX_XLEN 32
`endif

package ysyx_ifu_redirect_pkg;

  localparam int unsigned YSYX_FENCE_TIMEOUT = 32'd255;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FLUSH   = 3'd1,
    S_FENCE_T = 3'd2,
    S_FENCE_I = 3'd3,
    S_REDIR   = 3'd4
  } redir_state_e;

  // Store-buffer drain has priority over I-cache invalidate, which precedes the redirect.
  function automatic redir_state_e post_flush_state(input logic fence_time, input logic fence_i);
    redir_state_e nxt;
    if (fence_time) begin
      nxt = S_FENCE_T;
    end else if (fence_i) begin
      nxt = S_FENCE_I;
    end else begin
      nxt = S_REDIR;
    end
    return nxt;
  endfunction

  function automatic redir_state_e post_fence_t_state(input logic fence_i);
    redir_state_e nxt;
    if (fence_i) begin
      nxt = S_FENCE_I;
    end else begin
      nxt = S_REDIR;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/ysyx_ifu_redirect.sv
// ---------------------------------------------------------------------------
// ysyx_ifu_redirect
//   Turns a pipeline-flushing commit from the WBU into the front-end recovery
//   sequence: one-cycle flush pulse, optional store-buffer drain (fence),
//   optional I-cache invalidate (fence.i, with timeout), then an IFU redirect
//   to the committed npc.
//
//   Parameters : XLEN (PC width), FENCE_TIMEOUT (max fence.i ack wait cycles)
//   Ports      : clock, reset (async, active-low)
//                wbu_valid / wbu_ready          commit handshake
//                wbu_pc, wbu_npc, wbu_sys_retire, wbu_jen, wbu_ben,
//                wbu_fence_time, wbu_fence_i, wbu_flush_pipe   commit fields
//                flush                          front-end flush pulse
//                redir_valid / redir_pc / redir_ready          IFU redirect
//                icinv_req / icinv_ack          I-cache invalidate handshake
//                sb_empty                       store buffer drained
//                fence_timeout                  sticky fence.i timeout flag
//                btb_upd_*                      BTB update (only with
//                                               YSYX_BTB_UPDATE_EN defined)
//   Macro      : YSYX_BTB_UPDATE_EN enables the branch-predictor update port.
// ---------------------------------------------------------------------------
module ysyx_ifu_redirect
  import ysyx_ifu_redirect_pkg::*;
#(
  parameter int unsigned XLEN          = `YSYX_XLEN,
  parameter int unsigned FENCE_TIMEOUT = YSYX_FENCE_TIMEOUT
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wbu_valid,
  output logic            wbu_ready,
  input  logic [XLEN-1:0] wbu_pc,
  input  logic [XLEN-1:0] wbu_npc,
  input  logic            wbu_sys_retire,
  input  logic            wbu_jen,
  input  logic            wbu_ben,
  input  logic            wbu_fence_time,
  input  logic            wbu_fence_i,
  input  logic            wbu_flush_pipe,
  output logic            flush,
  output logic            redir_valid,
  output logic [XLEN-1:0] redir_pc,
  input  logic            redir_ready,
  output logic            icinv_req,
  input  logic            icinv_ack,
  input  logic            sb_empty,
  output logic            fence_timeout
`ifdef YSYX_BTB_UPDATE_EN
  ,
  output logic            btb_upd_valid,
  output logic [XLEN-1:0] btb_upd_pc,
  output logic [XLEN-1:0] btb_upd_tgt,
  output logic            btb_upd_jmp
`endif
);

  localparam int unsigned CNT_W = (FENCE_TIMEOUT > 32'd1) ? $clog2(FENCE_TIMEOUT) : 32'd1;
  // Counter value of the last FENCE_I cycle allowed before giving up on the ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FENCE_TIMEOUT - 32'd1);

  redir_state_e    state_r;
  logic            wbu_ready_r;
  logic            flush_r;
  logic            redir_valid_r;
  logic [XLEN-1:0] redir_pc_r;
  logic            icinv_req_r;
  logic            fence_timeout_r;
  logic [CNT_W-1:0] fence_cnt_r;
  logic            fence_time_r;
  logic            fence_i_r;
  logic            accept_s;

  assign accept_s = wbu_valid && wbu_ready_r;

  // Recovery sequencer: state plus all registered handshake/status outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r         <= S_IDLE;
      wbu_ready_r     <= 1'b1;
      flush_r         <= 1'b0;
      redir_valid_r   <= 1'b0;
      redir_pc_r      <= {XLEN{1'b0}};
      icinv_req_r     <= 1'b0;
      fence_timeout_r <= 1'b0;
      fence_cnt_r     <= {CNT_W{1'b0}};
      fence_time_r    <= 1'b0;
      fence_i_r       <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          fence_cnt_r <= {CNT_W{1'b0}};
          // sys_retire alone never redirects; only flush_pipe starts recovery.
          if (accept_s && wbu_flush_pipe) begin
            redir_pc_r   <= wbu_npc;
            fence_time_r <= wbu_fence_time;
            fence_i_r    <= wbu_fence_i;
            wbu_ready_r  <= 1'b0;
            flush_r      <= 1'b1;
            state_r      <= S_FLUSH;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_FLUSH: begin
          fence_cnt_r   <= {CNT_W{1'b0}};
          flush_r       <= 1'b0;
          state_r       <= post_flush_state(fence_time_r, fence_i_r);
          icinv_req_r   <= !fence_time_r && fence_i_r;
          redir_valid_r <= !fence_time_r && !fence_i_r;
        end
        S_FENCE_T: begin
          fence_cnt_r <= {CNT_W{1'b0}};
          if (sb_empty) begin
            state_r       <= post_fence_t_state(fence_i_r);
            icinv_req_r   <= fence_i_r;
            redir_valid_r <= !fence_i_r;
          end else begin
            state_r <= S_FENCE_T;
          end
        end
        S_FENCE_I: begin
          if (icinv_ack) begin
            icinv_req_r   <= 1'b0;
            redir_valid_r <= 1'b1;
            state_r       <= S_REDIR;
          end else if (fence_cnt_r == CNT_LAST) begin
            // Give up on the cache: flag it and still redirect so fetch resumes.
            icinv_req_r     <= 1'b0;
            redir_valid_r   <= 1'b1;
            fence_timeout_r <= 1'b1;
            state_r         <= S_REDIR;
          end else begin
            fence_cnt_r <= fence_cnt_r + CNT_W'(1);
            state_r     <= S_FENCE_I;
          end
        end
        S_REDIR: begin
          if (redir_ready) begin
            redir_valid_r <= 1'b0;
            wbu_ready_r   <= 1'b1;
            state_r       <= S_IDLE;
          end else begin
            state_r <= S_REDIR;
          end
        end
        default: begin
          state_r       <= S_IDLE;
          wbu_ready_r   <= 1'b1;
          flush_r       <= 1'b0;
          redir_valid_r <= 1'b0;
          icinv_req_r   <= 1'b0;
          fence_cnt_r   <= {CNT_W{1'b0}};
        end
      endcase
    end
  end

  assign wbu_ready     = wbu_ready_r;
  assign flush         = flush_r;
  assign redir_valid   = redir_valid_r;
  assign redir_pc      = redir_pc_r;
  assign icinv_req     = icinv_req_r;
  assign fence_timeout = fence_timeout_r;

`ifdef YSYX_BTB_UPDATE_EN
  logic            btb_upd_valid_r;
  logic [XLEN-1:0] btb_upd_pc_r;
  logic [XLEN-1:0] btb_upd_tgt_r;
  logic            btb_upd_jmp_r;

  // Branch-predictor training pulse, one cycle after any taken control-flow commit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      btb_upd_valid_r <= 1'b0;
      btb_upd_pc_r    <= {XLEN{1'b0}};
      btb_upd_tgt_r   <= {XLEN{1'b0}};
      btb_upd_jmp_r   <= 1'b0;
    end else if (accept_s && (wbu_jen || wbu_ben)) begin
      btb_upd_valid_r <= 1'b1;
      btb_upd_pc_r    <= wbu_pc;
      btb_upd_tgt_r   <= wbu_npc;
      // A jump that is also flagged as a branch is trained as a jump.
      btb_upd_jmp_r   <= wbu_jen;
    end else begin
      btb_upd_valid_r <= 1'b0;
    end
  end

  assign btb_upd_valid = btb_upd_valid_r;
  assign btb_upd_pc    = btb_upd_pc_r;
  assign btb_upd_tgt   = btb_upd_tgt_r;
  assign btb_upd_jmp   = btb_upd_jmp_r;

  logic unused_ok_s;
  assign unused_ok_s = wbu_sys_retire;
`else
  logic unused_ok_s;
  assign unused_ok_s = ^{wbu_sys_retire, wbu_pc, wbu_jen, wbu_ben};
`endif

endmodule
